// File: rtl/pipe_register_pkg.sv
// Shared definitions for the elastic pipeline register and its skid slices.
package pipe_register_pkg;

  // Entries held by one skid slice (main register plus skid register).
  localparam int unsigned SLICE_DEPTH = 2;

  // A transfer happens when the offering side is valid and the taking side is ready.
  function automatic logic hs_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/pipe_register_skid_slice.sv
// One elastic register slice: a 2-entry skid buffer with registered ready and
// registered downstream data/valid, so no combinational path crosses the slice.
module skid_slice
  import pipe_register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_valid,
  output logic             up_ready,
  output logic [WIDTH-1:0] dn_data,
  output logic             dn_valid,
  input  logic             dn_ready
);

  // Skid register sits on the upstream side (p0), main register drives downstream (p1).
  logic [WIDTH-1:0] skid_data_p0, skid_data_nxt;
  logic             vld_p0, vld_p0_nxt;
  logic [WIDTH-1:0] main_data_p1, main_data_nxt;
  logic             vld_p1, vld_p1_nxt;
  logic             up_hs, dn_hs;

  assign dn_data  = main_data_p1;
  assign dn_valid = vld_p1;

  // Decide where an accepted word lands and when the skid entry drains into main.
  always_comb begin
    up_hs         = hs_fire(up_valid, up_ready);
    dn_hs         = hs_fire(vld_p1, dn_ready);
    main_data_nxt = main_data_p1;
    skid_data_nxt = skid_data_p0;
    vld_p1_nxt    = vld_p1;
    vld_p0_nxt    = vld_p0;
    if (!vld_p1 || dn_hs) begin
      // Main frees up this edge: the older skid word has precedence. up_ready is
      // low whenever the skid is full, so no new word can arrive at the same time.
      if (vld_p0) begin
        main_data_nxt = skid_data_p0;
        vld_p1_nxt    = 1'b1;
        vld_p0_nxt    = 1'b0;
      end else begin
        vld_p1_nxt = up_hs;
        if (up_hs) main_data_nxt = up_data;
      end
    end else if (up_hs) begin
      // Main is stalled: park the word in the skid register.
      skid_data_nxt = up_data;
      vld_p0_nxt    = 1'b1;
    end
    // Flush drops every held entry and any word offered this cycle; the data
    // registers keep their contents so out_data does not glitch to the dropped word.
    if (flush) begin
      main_data_nxt = main_data_p1;
      skid_data_nxt = skid_data_p0;
      vld_p1_nxt    = 1'b0;
      vld_p0_nxt    = 1'b0;
    end
  end

  // State registers; ready is registered from the next skid occupancy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      skid_data_p0 <= '0;
      vld_p0       <= 1'b0;
      main_data_p1 <= '0;
      vld_p1       <= 1'b0;
      up_ready     <= 1'b1;
    end else begin
      skid_data_p0 <= skid_data_nxt;
      vld_p0       <= vld_p0_nxt;
      main_data_p1 <= main_data_nxt;
      vld_p1       <= vld_p1_nxt;
      up_ready     <= ~vld_p0_nxt;
    end
  end

endmodule

// File: rtl/pipe_register.sv
// Parametrised elastic pipeline register: STAGES skid slices chained dn->up,
// full throughput with backpressure, synchronous flush and an occupancy count.
module pipe_register
  import pipe_register_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = $clog2(SLICE_DEPTH * STAGES + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
);

  // Link k joins slice k-1 (or the producer) to slice k (or the consumer).
  logic [WIDTH-1:0] ch_data  [STAGES+1];
  logic             ch_valid [STAGES+1];
  logic             ch_ready [STAGES+1];
  logic             in_hs, out_hs;

  assign ch_data[0]       = in_data;
  assign ch_valid[0]      = in_valid;
  assign in_ready         = ch_ready[0];
  assign out_data         = ch_data[STAGES];
  assign out_valid        = ch_valid[STAGES];
  assign ch_ready[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    skid_slice #(.WIDTH(WIDTH)) u_slice (
      .CLK      (CLK),
      .RST      (RST),
      .flush    (flush),
      .up_data  (ch_data[k]),
      .up_valid (ch_valid[k]),
      .up_ready (ch_ready[k]),
      .dn_data  (ch_data[k+1]),
      .dn_valid (ch_valid[k+1]),
      .dn_ready (ch_ready[k+1])
    );
  end

  assign in_hs  = hs_fire(in_valid, in_ready);
  assign out_hs = hs_fire(out_valid, out_ready);

  // Occupancy tracks words inside the chain from the two boundary handshakes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + CNT_W'(in_hs) - CNT_W'(out_hs);
    end
  end

endmodule

// File: tb/tb_pipe_register.sv
// Bench for pipe_register: three instances (STAGES=2,1,3) share one stimulus
// stream; a per-slice queue model predicts every output cycle by cycle.
module tb_pipe_register;

  logic       CLK = 1'b0;
  logic       RST, flush, in_valid, out_ready;
  logic [7:0] in_data;

  logic [7:0] od0, od1, od2;
  logic       ov0, ov1, ov2, ir0, ir1, ir2;
  logic [2:0] occ0;
  logic [1:0] occ1;
  logic [2:0] occ2;

  logic [7:0] od [3];
  logic       ov [3];
  logic       ir [3];
  int         occ[3];

  int n_chk  = 0;
  int n_fail = 0;

  int st[3] = '{2, 1, 3};

  // Model state: queue per slice, index d*3+k (instance d, slice k), up to 2 words each.
  logic [7:0] mq[9][$];

  always #5 CLK = ~CLK;

  pipe_register #(.WIDTH(8), .STAGES(2)) u_s2 (
    .CLK(CLK), .RST(RST), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .occupancy(occ0));
  pipe_register #(.WIDTH(8), .STAGES(1)) u_s1 (
    .CLK(CLK), .RST(RST), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .occupancy(occ1));
  pipe_register #(.WIDTH(8), .STAGES(3)) u_s3 (
    .CLK(CLK), .RST(RST), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir2), .out_data(od2), .out_valid(ov2), .out_ready(out_ready), .occupancy(occ2));

  always_comb begin
    od[0] = od0; od[1] = od1; od[2] = od2;
    ov[0] = ov0; ov[1] = ov1; ov[2] = ov2;
    ir[0] = ir0; ir[1] = ir1; ir[2] = ir2;
    occ[0] = int'(occ0); occ[1] = int'(occ1); occ[2] = int'(occ2);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_total(input int d);
    int t = 0;
    for (int k = 0; k < st[d]; k++) t += mq[d*3+k].size();
    return t;
  endfunction

  // One clock edge of the model: every slice holds up to two words; a word moves
  // forward when the receiving slice held fewer than two at the start of the cycle.
  task automatic model_step(input int d);
    int         s;
    bit         ohs, ihs;
    bit         mv[3];
    logic [7:0] w;
    s   = st[d];
    ohs = (mq[d*3+s-1].size() > 0) && out_ready;
    ihs = in_valid && (mq[d*3].size() < 2);
    for (int k = 0; k < 3; k++) mv[k] = 1'b0;
    for (int k = 0; k < s - 1; k++)
      mv[k] = (mq[d*3+k].size() > 0) && (mq[d*3+k+1].size() < 2);
    if (flush) begin
      for (int k = 0; k < 3; k++) mq[d*3+k].delete();
    end else begin
      if (ohs) void'(mq[d*3+s-1].pop_front());
      for (int k = s - 2; k >= 0; k--) begin
        if (mv[k]) begin
          w = mq[d*3+k].pop_front();
          mq[d*3+k+1].push_back(w);
        end
      end
      if (ihs) mq[d*3].push_back(in_data);
    end
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 9; i++) mq[i].delete();
    end else begin
      for (int d = 0; d < 3; d++) model_step(d);
    end
  end

  // Every cycle out of reset, all instances must match the model.
  always @(negedge CLK) begin
    if (!RST) begin
      for (int d = 0; d < 3; d++) begin
        int  last;
        bit  mv_o;
        last = d*3 + st[d] - 1;
        mv_o = mq[last].size() > 0;
        chk($sformatf("model_out_valid[%0d]", d), int'(ov[d]), int'(mv_o));
        if (mv_o) chk($sformatf("model_out_data[%0d]", d), int'(od[d]), int'(mq[last][0]));
        chk($sformatf("model_in_ready[%0d]", d), int'(ir[d]), int'(mq[d*3].size() < 2));
        chk($sformatf("model_occupancy[%0d]", d), occ[d], m_total(d));
      end
    end
  end

  initial begin
    int acc;
    int got;
    bit a;

    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_out_valid", int'(ov[0]), 0);
    chk("reset_out_data", int'(od[0]), 8'h00);
    chk("reset_occupancy", occ[0], 0);
    chk("reset_in_ready", int'(ir[0]), 1);
    #1 RST = 1'b0;

    // Streaming 01..10 with the consumer always ready.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h01;
    @(posedge CLK); #1;
    chk("stream_latency_early", int'(ov[0]), 0);
    chk("stream_in_ready", int'(ir[0]), 1);
    for (int j = 2; j <= 16; j++) begin
      #1 in_data = 8'(j);
      @(posedge CLK); #1;
      chk("stream_valid", int'(ov[0]), 1);
      chk("stream_data", int'(od[0]), j - 1);
      chk("stream_in_ready", int'(ir[0]), 1);
    end
    #1 in_valid = 1'b0;
    @(posedge CLK); #1;
    chk("stream_last", int'(od[0]), 8'h10);
    repeat (4) @(posedge CLK);
    #2;

    // Backpressure: consumer stalled, producer offers A0, A1, ...
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      a = ir[0];
      @(posedge CLK); #2;
      if (a) acc++;
      in_data = 8'(8'hA0 + acc);
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc, 4);
    chk("bp_in_ready", int'(ir[0]), 0);
    chk("bp_occupancy", occ[0], 4);
    chk("bp_hold_data", int'(od[0]), 8'hA0);
    chk("bp_hold_valid", int'(ov[0]), 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge CLK); #1;
      chk("bp_drain_valid", int'(ov[0]), 1);
      chk("bp_drain_data", int'(od[0]), 8'hA0 + k);
      if (k == 2) chk("bp_ready_back", int'(ir[0]), 1);
      #1;
    end
    @(posedge CLK); #1;
    chk("bp_empty", int'(ov[0]), 0);
    #1;

    // Flush a full pipe while a word is offered.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hB0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      a = ir[0];
      @(posedge CLK); #2;
      if (a) acc++;
      in_data = 8'(8'hB0 + acc);
    end
    chk("flush_pre_occ", occ[0], 4);
    flush = 1'b1; in_data = 8'hFF; in_valid = 1'b1;
    @(posedge CLK); #1;
    chk("flush_out_valid", int'(ov[0]), 0);
    chk("flush_occupancy", occ[0], 0);
    chk("flush_in_ready", int'(ir[0]), 1);
    #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      chk("flush_no_ff", int'(ov[0]), 0);
      #1;
    end

    // Flush held high: accepted words are dropped.
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hFE;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      chk("flush_hold_occ", occ[0], 0);
      chk("flush_hold_ready", int'(ir[0]), 1);
      #1;
    end
    flush = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #2;

    // Asynchronous reset in the middle of a stream.
    out_ready = 1'b1; in_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      in_data = 8'(8'h10 + j);
      @(posedge CLK); #2;
    end
    @(negedge CLK); #1;
    RST = 1'b1;
    #1;
    chk("async_rst_out_valid", int'(ov[0]), 0);
    chk("async_rst_out_data", int'(od[0]), 8'h00);
    chk("async_rst_occupancy", occ[0], 0);
    chk("async_rst_in_ready", int'(ir[0]), 1);
    in_valid = 1'b0;
    @(posedge CLK); #2;
    RST = 1'b0; in_valid = 1'b1; in_data = 8'h55; got = -1;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      if (got < 0 && ov[0]) got = int'(od[0]);
      #1 in_data = in_data + 8'h01;
    end
    chk("rst_first_word", got, 8'h55);
    in_valid = 1'b0;
    repeat (4) @(posedge CLK);
    #2;

    // Random valid/ready traffic; the producer holds its word until it is taken.
    in_valid = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      a = in_valid && ir[0];
      @(posedge CLK); #2;
      if (!(in_valid && !a)) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end
      out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    chk("drain_occ_s2", occ[0], 0);
    chk("drain_occ_s1", occ[1], 0);
    chk("drain_occ_s3", occ[2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
